// File: rtl/pwm_audio_rx.sv
// PWM audio receiver: measures high time per PWM frame and queues the recovered samples.
// Optional two-frame averaging is enabled with the PWM_AUDIO_RX_AVG_EN macro.
module pwm_audio_rx #(
  parameter int PERIOD_CLKS = 256,
  parameter int SAMPLE_W    = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                CLK100MHZ,
  input  logic                BTNC,
  input  logic                pwm_in,
  input  logic                sample_ready,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  output logic                locked,
  output logic                overflow
);
  localparam int FW   = $clog2(PERIOD_CLKS);
  localparam int HW   = $clog2(PERIOD_CLKS + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXS = (1 << SAMPLE_W) - 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(PERIOD_CLKS - 1);

  typedef enum logic [1:0] {HUNT = 2'd0, TRACK = 2'd1, RESYNC = 2'd2} state_t;

  state_t              state;
  logic                s1, s, s_d;
  logic [FW-1:0]       frm_cnt;
  logic [HW-1:0]       hi_cnt;
  logic [HW-1:0]       final_cnt;
  logic [SAMPLE_W-1:0] sat;
  logic [SAMPLE_W-1:0] push_val;
  logic                rise, misalign, frame_end;
  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]         wp, rp;
  logic                empty, full, pop, push_ok;

  // Two-flop synchronizer plus a delay flop for edge detection
  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      s1  <= 1'b0;
      s   <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s1  <= pwm_in;
      s   <= s1;
      s_d <= s;
    end
  end

  assign rise      = s & ~s_d;
  assign misalign  = (state == TRACK) && rise && (frm_cnt != '0);
  assign frame_end = (state != HUNT) && !misalign && (frm_cnt == FRM_LAST);
  assign final_cnt = hi_cnt + HW'(s);

  // Saturate the frame's high count into the sample range
  always_comb begin
    sat = '0;
    if (32'(final_cnt) > 32'(MAXS)) begin
      sat = SAMPLE_W'(MAXS);
    end else begin
      sat = SAMPLE_W'(final_cnt);
    end
  end

`ifdef PWM_AUDIO_RX_AVG_EN
  logic [SAMPLE_W-1:0] prev;
  logic [SAMPLE_W:0]   avg_sum;

  assign avg_sum  = {1'b0, sat} + {1'b0, prev} + {{SAMPLE_W{1'b0}}, 1'b1};
  assign push_val = avg_sum[SAMPLE_W:1];

  // prev restarts from zero whenever alignment is (re)acquired
  always_ff @(posedge CLK100MHZ) begin
    if (BTNC || state == HUNT || misalign) begin
      prev <= '0;
    end else if (frame_end) begin
      prev <= sat;
    end else begin
      prev <= prev;
    end
  end
`else
  assign push_val = sat;
`endif

  // Frame alignment FSM with frame and high-time counters
  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      state   <= HUNT;
      locked  <= 1'b0;
      frm_cnt <= '0;
      hi_cnt  <= '0;
    end else begin
      case (state)
        HUNT: begin
          if (rise) begin
            state   <= TRACK;
            locked  <= 1'b1;
            frm_cnt <= FW'(1);
            hi_cnt  <= HW'(1);
          end else begin
            state   <= HUNT;
            locked  <= 1'b0;
            frm_cnt <= '0;
            hi_cnt  <= '0;
          end
        end
        TRACK, RESYNC: begin
          if (misalign) begin
            // the misaligned rise is cycle 0 of the new frame
            state   <= RESYNC;
            locked  <= 1'b0;
            frm_cnt <= FW'(1);
            hi_cnt  <= HW'(1);
          end else if (frame_end) begin
            state   <= TRACK;
            locked  <= 1'b1;
            frm_cnt <= '0;
            hi_cnt  <= '0;
          end else begin
            state   <= TRACK;
            locked  <= 1'b1;
            frm_cnt <= frm_cnt + FW'(1);
            hi_cnt  <= final_cnt;
          end
        end
        default: begin
          state   <= HUNT;
          locked  <= 1'b0;
          frm_cnt <= '0;
          hi_cnt  <= '0;
        end
      endcase
    end
  end

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop     = ~empty & sample_ready;
  assign push_ok = frame_end && (!full || pop);

  // Output FIFO with sticky overflow on a dropped push
  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wp[AW-1:0]] <= push_val;
        wp              <= wp + (AW+1)'(1);
      end
      if (pop) begin
        rp <= rp + (AW+1)'(1);
      end
      if (frame_end && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign sample_valid = ~empty;
  assign sample_data  = mem[rp[AW-1:0]];
endmodule

// File: tb/tb_pwm_audio_rx.sv
// Self-checking bench for pwm_audio_rx: directed frame tables, FIFO/reset corners and random duties
// against a queue-based sample model.
module tb_pwm_audio_rx;
  localparam int P    = 256;
  localparam int D    = 4;
  localparam int MAXV = 255;

  logic       clk = 1'b0;
  logic       btnc = 1'b1;
  logic       pwm_in = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, locked, overflow;

  int checks = 0, errors = 0;
  int hs = 0, unlocked = 0;
  int exp_q[$];
  bit rand_ready = 1'b0;
`ifdef PWM_AUDIO_RX_AVG_EN
  int prev = 0;
`endif

  typedef struct {int hi; int exp;} vec_t;
  vec_t tbl[12];

  pwm_audio_rx #(.PERIOD_CLKS(P), .SAMPLE_W(8), .FIFO_DEPTH(D)) dut (
    .CLK100MHZ(clk), .BTNC(btnc), .pwm_in(pwm_in), .sample_ready(ready),
    .sample_data(data), .sample_valid(valid), .locked(locked), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every accepted sample must match the head of the model queue
  always @(negedge clk) begin
    if (!btnc) begin
      if (!locked) unlocked++;
      if (valid && ready) begin
        hs++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_sample: got %0d expected none", data);
        end else begin
          check("sample", int'(data), exp_q.pop_front());
        end
      end
    end
  end

  // Model: one sample per full frame, saturated, dropped when four are already waiting
  task automatic model_push(input int raw);
    int sv, v;
    sv = (raw > MAXV) ? MAXV : raw;
`ifdef PWM_AUDIO_RX_AVG_EN
    v = (sv + prev + 1) / 2;
    prev = sv;
`else
    v = sv;
`endif
    if (exp_q.size() < D) exp_q.push_back(v);
  endtask

  task automatic model_relock();
`ifdef PWM_AUDIO_RX_AVG_EN
    prev = 0;
`endif
  endtask

  task automatic drive_seg(input bit lvl, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = lvl;
      if (rand_ready) ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input int h);
    drive_seg(1'b1, h);
    drive_seg(1'b0, P - h);
    model_push(h);
  endtask

  initial begin
    int u0, h0, h;
    tbl = '{'{64, 64}, '{64, 64}, '{0, 0}, '{0, 0}, '{0, 0}, '{256, 255},
            '{256, 255}, '{200, 200}, '{255, 255}, '{1, 1}, '{128, 128}, '{256, 255}};

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(valid), 0);
    check("rst_data", int'(data), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_overflow", int'(overflow), 0);
    btnc = 1'b0;
    drive_seg(1'b0, 4);
    check("hunt_idle", int'(locked), 0);

    // first frame 64/192: lock three clocks after the input rise
    drive_seg(1'b1, 2);
    check("lock_early", int'(locked), 0);
    drive_seg(1'b1, 1);
    check("lock_3clk", int'(locked), 1);
    drive_seg(1'b1, 61);
    drive_seg(1'b0, P - 64);
    model_push(64);
    u0 = unlocked;
    h0 = hs;

    foreach (tbl[i]) begin
      drive_seg(1'b1, tbl[i].hi);
      drive_seg(1'b0, P - tbl[i].hi);
      model_push(tbl[i].exp);
    end

    // misaligned rise 37 clocks into a 100% frame
    drive_seg(1'b1, 36);
    check("table_samples", hs - h0, 13);
    check("table_queue_empty", exp_q.size(), 0);
    check("locked_held", unlocked - u0, 0);
    drive_seg(1'b0, 1);
    model_relock();
    frame(100);
    check("resync_one_cycle", unlocked - u0, 1);

    // FIFO fill with consumer stalled
    drive_seg(1'b1, 4);
    ready = 1'b0;
    drive_seg(1'b1, 6);
    drive_seg(1'b0, P - 10);
    model_push(10);
    frame(20);
    frame(30);
    frame(40);
    frame(50);
    check("ovf_before_5th", int'(overflow), 0);
    check("full_valid", int'(valid), 1);
    frame(60);
    check("ovf_after_5th", int'(overflow), 1);
    drive_seg(1'b0, 4);
    check("model_depth", exp_q.size(), 4);
    check("head_stable", int'(data), exp_q[0]);
    ready = 1'b1;
    drive_seg(1'b0, 6);
    check("drained_valid", int'(valid), 0);
    check("drained_all", exp_q.size(), 0);
    check("ovf_sticky", int'(overflow), 1);
    drive_seg(1'b0, P - 10);
    model_push(0);

    // reset mid-frame with two samples queued
    drive_seg(1'b1, 4);
    ready = 1'b0;
    drive_seg(1'b1, 1);
    drive_seg(1'b0, P - 5);
    model_push(5);
    frame(7);
    drive_seg(1'b1, 20);
    check("queued_two", exp_q.size(), 2);
    check("queued_valid", int'(valid), 1);
    check("queued_head", int'(data), exp_q[0]);
    btnc = 1'b1;
    pwm_in = 1'b0;
    @(posedge clk);
    #1;
    btnc = 1'b0;
    exp_q.delete();
    model_relock();
    check("srst_valid", int'(valid), 0);
    check("srst_locked", int'(locked), 0);
    check("srst_overflow", int'(overflow), 0);
    check("srst_data", int'(data), 0);
    ready = 1'b1;
    drive_seg(1'b0, 6);
    check("srst_hunt", int'(locked), 0);
    drive_seg(1'b1, 3);
    check("relock", int'(locked), 1);
    drive_seg(1'b1, 125);
    drive_seg(1'b0, P - 128);
    model_push(128);

    // random duties with a randomly stalling consumer
    rand_ready = 1'b1;
    repeat (20) begin
      h = int'($urandom_range(0, P));
      frame(h);
    end
    rand_ready = 1'b0;
    ready = 1'b1;
    drive_seg(1'b0, 10);
    check("random_all_seen", exp_q.size(), 0);
    check("random_no_ovf", int'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
